// File: rtl/snn_cfg_loader.sv
// snn_cfg_loader: APB master that walks a {paddr, pwdata} config memory,
// writes each entry to a layer CSR block, optionally reads it back to
// compare, then writes the layer control register to enable the layer.
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   start, verify_en            load request pulse, readback-compare select
//   num_entries                 entries to load (clamped to CFG_DEPTH)
//   cfg_rd_en/addr/data         config memory read port (1-cycle latency)
//   psel..pready                APB master port
//   busy, done                  sequence in progress, end-of-sequence pulse
//   error, err_index            sticky mismatch flag, first bad entry index
module snn_cfg_loader #(
    parameter int          CFG_DEPTH       = 64,
    parameter int          CFG_AW          = $clog2(CFG_DEPTH),
    parameter logic [15:0] CTRL_ADDR       = 16'h3000,
    parameter logic [31:0] CTRL_ENABLE_VAL = 32'h0000_0001
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              verify_en,
    input  logic [CFG_AW:0]   num_entries,
    output logic              cfg_rd_en,
    output logic [CFG_AW-1:0] cfg_rd_addr,
    input  logic [47:0]       cfg_rd_data,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [15:0]       paddr,
    output logic [31:0]       pwdata,
    input  logic [31:0]       prdata,
    input  logic              pready,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [CFG_AW-1:0] err_index
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_WR_SETUP,
        S_WR_ACCESS,
        S_RD_SETUP,
        S_RD_ACCESS,
        S_NEXT,
        S_CTRL_SETUP,
        S_CTRL_ACCESS,
        S_DONE
    } state_t;

    localparam logic [CFG_AW:0] DEPTH_C = (CFG_AW+1)'(CFG_DEPTH);
    localparam logic [CFG_AW:0] ONE_C   = (CFG_AW+1)'(1);

    state_t              r_state;
    logic [CFG_AW-1:0]   r_idx;
    logic [CFG_AW:0]     r_count;
    logic                r_verify;
    logic                r_cfg_rd_en;
    logic                r_psel;
    logic                r_penable;
    logic                r_pwrite;
    logic [15:0]         r_paddr;
    logic [31:0]         r_pwdata;
    logic                r_busy;
    logic                r_done;
    logic                r_error;
    logic [CFG_AW-1:0]   r_err_index;

    logic [CFG_AW:0]     w_count;
    logic                w_last;

    // Requests beyond the memory depth are clamped so idx never wraps.
    assign w_count = (num_entries > DEPTH_C) ? DEPTH_C : num_entries;
    assign w_last  = ({1'b0, r_idx} == (r_count - ONE_C));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_idx       <= '0;
            r_count     <= '0;
            r_verify    <= 1'b0;
            r_cfg_rd_en <= 1'b0;
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
            r_pwrite    <= 1'b0;
            r_paddr     <= '0;
            r_pwdata    <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
            r_err_index <= '0;
        end else begin
            r_done      <= 1'b0;
            r_cfg_rd_en <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_verify    <= verify_en;
                        r_count     <= w_count;
                        r_error     <= 1'b0;
                        r_err_index <= '0;
                        r_idx       <= '0;
                        r_busy      <= 1'b1;
                        if (w_count == '0) begin
                            r_paddr  <= CTRL_ADDR;
                            r_pwdata <= CTRL_ENABLE_VAL;
                            r_psel   <= 1'b1;
                            r_pwrite <= 1'b1;
                            r_state  <= S_CTRL_SETUP;
                        end else begin
                            r_cfg_rd_en <= 1'b1;
                            r_state     <= S_FETCH;
                        end
                    end
                end
                S_FETCH: begin
                    r_state <= S_LOAD;
                end
                S_LOAD: begin
                    r_paddr  <= cfg_rd_data[47:32];
                    r_pwdata <= cfg_rd_data[31:0];
                    r_psel   <= 1'b1;
                    r_pwrite <= 1'b1;
                    r_state  <= S_WR_SETUP;
                end
                S_WR_SETUP: begin
                    r_penable <= 1'b1;
                    r_state   <= S_WR_ACCESS;
                end
                S_WR_ACCESS: begin
                    if (pready) begin
                        r_penable <= 1'b0;
                        r_pwrite  <= 1'b0;
                        if (r_verify) begin
                            r_state <= S_RD_SETUP;
                        end else begin
                            r_psel  <= 1'b0;
                            r_state <= S_NEXT;
                        end
                    end
                end
                S_RD_SETUP: begin
                    r_penable <= 1'b1;
                    r_state   <= S_RD_ACCESS;
                end
                S_RD_ACCESS: begin
                    if (pready) begin
                        r_psel    <= 1'b0;
                        r_penable <= 1'b0;
                        if (prdata != r_pwdata) begin
                            // Abort: the layer is left disabled.
                            r_error     <= 1'b1;
                            r_err_index <= r_idx;
                            r_done      <= 1'b1;
                            r_state     <= S_DONE;
                        end else begin
                            r_state <= S_NEXT;
                        end
                    end
                end
                S_NEXT: begin
                    if (w_last) begin
                        r_paddr  <= CTRL_ADDR;
                        r_pwdata <= CTRL_ENABLE_VAL;
                        r_psel   <= 1'b1;
                        r_pwrite <= 1'b1;
                        r_state  <= S_CTRL_SETUP;
                    end else begin
                        r_idx       <= r_idx + 1'b1;
                        r_cfg_rd_en <= 1'b1;
                        r_state     <= S_FETCH;
                    end
                end
                S_CTRL_SETUP: begin
                    r_penable <= 1'b1;
                    r_state   <= S_CTRL_ACCESS;
                end
                S_CTRL_ACCESS: begin
                    if (pready) begin
                        r_psel    <= 1'b0;
                        r_penable <= 1'b0;
                        r_pwrite  <= 1'b0;
                        r_done    <= 1'b1;
                        r_state   <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign cfg_rd_en   = r_cfg_rd_en;
    assign cfg_rd_addr = r_idx;
    assign psel        = r_psel;
    assign penable     = r_penable;
    assign pwrite      = r_pwrite;
    assign paddr       = r_paddr;
    assign pwdata      = r_pwdata;
    assign busy        = r_busy;
    assign done        = r_done;
    assign error       = r_error;
    assign err_index   = r_err_index;

endmodule

// File: tb/tb_snn_cfg_loader.sv
// tb_snn_cfg_loader: directed vector bench for snn_cfg_loader with a
// config memory model and an APB slave model with wait-state control.
module tb_snn_cfg_loader;

    localparam int DEPTH = 64;
    localparam int AW    = 6;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          verify_en = 1'b0;
    logic [AW:0]   num_entries = '0;
    logic          cfg_rd_en;
    logic [AW-1:0] cfg_rd_addr;
    logic [47:0]   cfg_rd_data = '0;
    logic          psel;
    logic          penable;
    logic          pwrite;
    logic [15:0]   paddr;
    logic [31:0]   pwdata;
    logic [31:0]   prdata = '0;
    logic          pready = 1'b1;
    logic          busy;
    logic          done;
    logic          error;
    logic [AW-1:0] err_index;

    snn_cfg_loader #(.CFG_DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .verify_en   (verify_en),
        .num_entries (num_entries),
        .cfg_rd_en   (cfg_rd_en),
        .cfg_rd_addr (cfg_rd_addr),
        .cfg_rd_data (cfg_rd_data),
        .psel        (psel),
        .penable     (penable),
        .pwrite      (pwrite),
        .paddr       (paddr),
        .pwdata      (pwdata),
        .prdata      (prdata),
        .pready      (pready),
        .busy        (busy),
        .done        (done),
        .error       (error),
        .err_index   (err_index)
    );

    always #5 clk = ~clk;

    logic [47:0] mem [DEPTH];

    always @(posedge clk) begin
        if (cfg_rd_en) cfg_rd_data <= mem[cfg_rd_addr];
    end

    // Slave knobs, written only by the stimulus side.
    int          t_waits = 0;
    bit          t_bad = 1'b0;
    logic [15:0] t_bad_addr = '0;

    // Per-run observations, cleared when busy rises.
    int          m_wr, m_rd, m_fetch, m_max, m_viol, m_order, m_widx;
    bit          m_ctrl;
    int          wcnt;
    logic [31:0] last_wd;
    logic [15:0] last_wa;
    logic        p_psel, p_pen, p_rdy, p_wr, p_busy;
    logic [15:0] p_addr;
    logic [31:0] p_data;

    always @(negedge clk) begin
        if (!rst_n) begin
            p_psel = 0; p_pen = 0; p_rdy = 0; p_wr = 0; p_busy = 0;
            p_addr = '0; p_data = '0; wcnt = 0;
            pready = (t_waits == 0);
        end else begin
            if (busy && !p_busy) begin
                m_wr = 0; m_rd = 0; m_fetch = 0; m_max = 0;
                m_viol = 0; m_order = 0; m_widx = 0; m_ctrl = 0;
                last_wd = '0; last_wa = '0;
            end
            // Setup or stalled access must be followed by an identical access.
            if (p_psel && (!p_pen || !p_rdy)) begin
                if (!(psel && penable && paddr == p_addr &&
                      pwdata == p_data && pwrite == p_wr))
                    m_viol++;
            end
            if (cfg_rd_en) begin
                m_fetch++;
                if (int'(cfg_rd_addr) > m_max) m_max = int'(cfg_rd_addr);
            end
            if (psel && penable) begin
                pready = (wcnt >= t_waits);
                wcnt++;
            end else begin
                wcnt = 0;
                pready = (t_waits == 0);
            end
            prdata = (t_bad && paddr == t_bad_addr) ? 32'hDEAD_BEEF : last_wd;
            if (psel && penable && pready) begin
                if (pwrite) begin
                    m_wr++;
                    if (m_ctrl) m_order++;
                    if (paddr == 16'h3000) begin
                        m_ctrl = 1;
                        if (pwdata != 32'h1) m_order++;
                    end else begin
                        if (m_widx >= DEPTH || {paddr, pwdata} != mem[m_widx])
                            m_order++;
                        m_widx++;
                    end
                    last_wd = pwdata;
                    last_wa = paddr;
                end else begin
                    m_rd++;
                    if (paddr != last_wa) m_order++;
                end
            end
            p_psel = psel; p_pen = penable; p_rdy = pready; p_wr = pwrite;
            p_addr = paddr; p_data = pwdata; p_busy = busy;
        end
    end

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    typedef struct {
        int          num;
        bit          ver;
        int          waits;
        bit          bad;
        logic [15:0] bad_addr;
        int          extra_at;
        int          e_done;
        int          e_wr;
        int          e_rd;
        int          e_fetch;
        int          e_err;
        int          e_eidx;
        int          e_ctrl;
        int          e_max;
    } vec_t;

    task automatic do_vec(input int id, input vec_t v);
        int done_at, pulses, busy1;
        t_waits = v.waits;
        t_bad = v.bad;
        t_bad_addr = v.bad_addr;
        @(negedge clk);
        verify_en = v.ver;
        num_entries = v.num[AW:0];
        start = 1'b1;
        done_at = 0; pulses = 0; busy1 = 0;
        for (int k = 1; k <= 3000; k++) begin
            @(negedge clk);
            if (k == 1) begin
                start = 1'b0;
                busy1 = int'(busy);
            end
            if (v.extra_at != 0 && k == v.extra_at) start = 1'b1;
            if (v.extra_at != 0 && k == v.extra_at + 1) start = 1'b0;
            if (done) begin
                pulses++;
                if (done_at == 0) done_at = k;
            end
            if (done_at != 0 && k >= done_at + 4) break;
        end
        chk($sformatf("v%0d_done_cycle", id), done_at, v.e_done);
        chk($sformatf("v%0d_done_pulses", id), pulses, 1);
        chk($sformatf("v%0d_busy_early", id), busy1, 1);
        chk($sformatf("v%0d_busy_after", id), int'(busy), 0);
        chk($sformatf("v%0d_writes", id), m_wr, v.e_wr);
        chk($sformatf("v%0d_reads", id), m_rd, v.e_rd);
        chk($sformatf("v%0d_fetches", id), m_fetch, v.e_fetch);
        chk($sformatf("v%0d_max_rd_addr", id), m_max, v.e_max);
        chk($sformatf("v%0d_error", id), int'(error), v.e_err);
        chk($sformatf("v%0d_err_index", id), int'(err_index), v.e_eidx);
        chk($sformatf("v%0d_ctrl_write", id), int'(m_ctrl), v.e_ctrl);
        chk($sformatf("v%0d_apb_stable", id), m_viol, 0);
        chk($sformatf("v%0d_wr_order", id), m_order, 0);
    endtask

    vec_t vt [10];
    vec_t v_plain;

    initial begin
        int found;
        mem[0] = {16'h0000, 32'hA5A5_0001};
        mem[1] = {16'h2004, 32'h0000_0123};
        for (int i = 2; i < DEPTH; i++)
            mem[i] = {16'h1000 + 16'(4 * i), 32'hC0DE_0000 + 32'(i)};

        vt[0] = '{2,   0, 0, 0, 16'h0000, 0, 13,  3,  0, 2,  0, 0, 1, 1};
        vt[1] = '{2,   1, 0, 0, 16'h0000, 0, 17,  3,  2, 2,  0, 0, 1, 1};
        vt[2] = '{2,   1, 0, 1, 16'h2004, 0, 14,  2,  2, 2,  1, 1, 0, 1};
        vt[3] = '{1,   0, 0, 0, 16'h0000, 0, 8,   2,  0, 1,  0, 0, 1, 0};
        vt[4] = '{2,   0, 3, 0, 16'h0000, 0, 22,  3,  0, 2,  0, 0, 1, 1};
        vt[5] = '{2,   1, 3, 0, 16'h0000, 0, 32,  3,  2, 2,  0, 0, 1, 1};
        vt[6] = '{0,   0, 0, 0, 16'h0000, 0, 3,   1,  0, 0,  0, 0, 1, 0};
        vt[7] = '{100, 0, 0, 0, 16'h0000, 0, 323, 65, 0, 64, 0, 0, 1, 63};
        vt[8] = '{3,   1, 0, 1, 16'h1008, 0, 21,  3,  3, 3,  1, 2, 0, 2};
        vt[9] = '{2,   0, 0, 0, 16'h0000, 4, 13,  3,  0, 2,  0, 0, 1, 1};
        v_plain = vt[0];

        repeat (3) @(negedge clk);
        chk("rst_psel", int'(psel), 0);
        chk("rst_penable", int'(penable), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_error", int'(error), 0);
        chk("rst_cfg_rd_en", int'(cfg_rd_en), 0);
        chk("rst_paddr", int'(paddr), 0);
        chk("rst_err_index", int'(err_index), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 10; i++) do_vec(i, vt[i]);

        // Reset while a write access is stalled by the slave.
        t_waits = 3;
        t_bad = 1'b0;
        @(negedge clk);
        verify_en = 1'b0;
        num_entries = 7'd2;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        found = 0;
        for (int k = 0; k < 100; k++) begin
            if (psel && penable && pwrite) begin
                found = 1;
                break;
            end
            @(negedge clk);
        end
        chk("rst_mid_reached_wr_access", found, 1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_psel", int'(psel), 0);
        chk("rst_mid_penable", int'(penable), 0);
        chk("rst_mid_busy", int'(busy), 0);
        chk("rst_mid_done", int'(done), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_vec(99, v_plain);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
